// File: rtl/rheed_pkg.sv
// Shared state encoding and frame-geometry helpers for the RHEED frame sequencer.
package rheed_pkg;

    localparam int unsigned PIXELS_PER_BEAT = 32;

    typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE, FLUSH} state_e;

    function automatic int unsigned beats_per_frame(input int unsigned rows,
                                                    input int unsigned cols,
                                                    input int unsigned ppb);
        return (rows * cols) / ppb;
    endfunction

endpackage

// File: rtl/rheed_watchdog.sv
// Stall watchdog: counts enabled cycles without a kick, expires after TIMEOUT_CYCLES of them.
module rheed_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = enable && !kick && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!enable || kick || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rheed_frame_ctrl.sv
// Frame sequencer for the RHEED pipeline: arms one frame, gates its input beats,
// watches output pixels for completion and flushes the pipeline on abort or stall.
module rheed_frame_ctrl #(
    parameter int unsigned IN_ROWS         = 64,
    parameter int unsigned IN_COLS         = 64,
    parameter int unsigned OUT_ROWS        = 32,
    parameter int unsigned OUT_COLS        = 32,
    parameter int unsigned PIXELS_PER_BEAT = rheed_pkg::PIXELS_PER_BEAT,
    parameter int unsigned TIMEOUT_CYCLES  = 1048576,
    parameter int unsigned FLUSH_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ctrl_enable,
    input  logic                       ctrl_continuous,
    input  logic                       ctrl_abort,
    input  logic                       cfg_we,
    input  logic [$clog2(IN_COLS)-1:0] cfg_crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0] cfg_crop_y0,
    input  logic                       us_tvalid,
    output logic                       us_tready,
    output logic                       ds_tvalid,
    input  logic                       ds_tready,
    input  logic                       pix_tvalid,
    input  logic                       pix_tready,
    output logic                       pipe_ap_start,
    output logic                       pipe_reset,
    output logic [$clog2(IN_COLS)-1:0] pipe_crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] pipe_crop_y0,
    output logic                       sts_busy,
    output logic                       sts_frame_done,
    output logic [31:0]                sts_frame_cnt,
    output logic                       sts_timeout,
    output logic                       sts_cfg_err
);

    import rheed_pkg::*;

    localparam int unsigned XW      = $clog2(IN_COLS);
    localparam int unsigned YW      = $clog2(IN_ROWS);
    localparam int unsigned BEATS   = beats_per_frame(IN_ROWS, IN_COLS, PIXELS_PER_BEAT);
    localparam int unsigned OUT_PIX = OUT_ROWS * OUT_COLS;
    localparam int unsigned BW      = $clog2(BEATS + 1);
    localparam int unsigned PW      = $clog2(OUT_PIX + 1);
    localparam int unsigned FW      = $clog2(FLUSH_CYCLES + 1);

    localparam logic [BW-1:0] BEATS_L    = BW'(BEATS);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
    localparam logic [PW-1:0] OUT_PIX_L  = PW'(OUT_PIX);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] beat_cnt_q;
    logic [PW-1:0] pix_cnt_q;
    logic [FW-1:0] flush_cnt_q;
    logic          en_prev_q;
    logic [XW-1:0] stage_x_q, act_x_q;
    logic [YW-1:0] stage_y_q, act_y_q;
    logic          ap_start_q, flush_q, busy_q, done_q, timeout_q, cfg_err_q;
    logic [31:0]   frame_cnt_q;

    logic gate, beat_hs, pix_hs, in_frame, en_rise, cfg_ok, wd_expire;

    assign gate      = (state_q == RUN) && (beat_cnt_q < BEATS_L);
    assign ds_tvalid = us_tvalid & gate;
    assign us_tready = ds_tready & gate;
    assign beat_hs   = ds_tvalid & ds_tready;
    assign pix_hs    = pix_tvalid & pix_tready;
    assign in_frame  = (state_q == RUN) || (state_q == DRAIN);
    assign en_rise   = ctrl_enable & ~en_prev_q;
    assign cfg_ok    = ((32'(cfg_crop_x0) + OUT_COLS) <= IN_COLS) &&
                       ((32'(cfg_crop_y0) + OUT_ROWS) <= IN_ROWS);

    rheed_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .enable (in_frame),
        .kick   (beat_hs | pix_hs),
        .expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_rise || (ctrl_enable && ctrl_continuous)) state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (beat_hs && (beat_cnt_q == BEAT_LAST)) state_d = DRAIN;
            DRAIN:   if (pix_cnt_q == OUT_PIX_L) state_d = DONE;
            DONE:    state_d = (ctrl_enable && ctrl_continuous) ? ARM : IDLE;
            FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort/stall override any completion in the same cycle, so no done pulse follows.
        if (in_frame && (ctrl_abort || wd_expire)) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            en_prev_q   <= 1'b0;
            beat_cnt_q  <= '0;
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
            stage_x_q   <= '0;
            stage_y_q   <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            ap_start_q  <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            timeout_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_prev_q  <= ctrl_enable;
            ap_start_q <= (state_d == ARM);
            flush_q    <= (state_d == FLUSH);
            busy_q     <= (state_d == ARM) || (state_d == RUN) ||
                          (state_d == DRAIN) || (state_d == FLUSH);
            done_q     <= (state_d == DONE);
            if (state_d == DONE) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end

            if ((state_q == ARM) || (state_q == FLUSH)) begin
                beat_cnt_q <= '0;
                pix_cnt_q  <= '0;
            end else begin
                if (beat_hs) begin
                    beat_cnt_q <= beat_cnt_q + BW'(1);
                end
                if (in_frame && pix_hs && (pix_cnt_q != OUT_PIX_L)) begin
                    pix_cnt_q <= pix_cnt_q + PW'(1);
                end
            end
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + FW'(1) : '0;

            // ARM samples staging before a same-cycle cfg_we lands, so new values wait a frame.
            if (state_q == ARM) begin
                act_x_q <= stage_x_q;
                act_y_q <= stage_y_q;
            end
            if (cfg_we && cfg_ok) begin
                stage_x_q <= cfg_crop_x0;
                stage_y_q <= cfg_crop_y0;
            end

            timeout_q <= (timeout_q & ~en_rise) | (in_frame & wd_expire);
            cfg_err_q <= (cfg_err_q & ~en_rise) | (cfg_we & ~cfg_ok);
        end
    end

    assign pipe_ap_start  = ap_start_q;
    assign pipe_reset     = reset | flush_q;
    assign pipe_crop_x0   = act_x_q;
    assign pipe_crop_y0   = act_y_q;
    assign sts_busy       = busy_q;
    assign sts_frame_done = done_q;
    assign sts_frame_cnt  = frame_cnt_q;
    assign sts_timeout    = timeout_q;
    assign sts_cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_rheed_frame_ctrl.sv
// Directed bench for rheed_frame_ctrl; the DUT runs with a 64-cycle stall watchdog.
`timescale 1ns/1ps
module tb_rheed_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset, ctrl_enable, ctrl_continuous, ctrl_abort, cfg_we;
    logic [5:0] cfg_crop_x0, cfg_crop_y0;
    logic       us_tvalid, us_tready, ds_tvalid, ds_tready, pix_tvalid, pix_tready;
    logic       pipe_ap_start, pipe_reset, sts_busy, sts_frame_done, sts_timeout, sts_cfg_err;
    logic [5:0] pipe_crop_x0, pipe_crop_y0;
    logic [31:0] sts_frame_cnt;

    always #5 clk = ~clk;

    rheed_frame_ctrl #(
        .TIMEOUT_CYCLES(64),
        .FLUSH_CYCLES  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_enable    (ctrl_enable),
        .ctrl_continuous(ctrl_continuous),
        .ctrl_abort     (ctrl_abort),
        .cfg_we         (cfg_we),
        .cfg_crop_x0    (cfg_crop_x0),
        .cfg_crop_y0    (cfg_crop_y0),
        .us_tvalid      (us_tvalid),
        .us_tready      (us_tready),
        .ds_tvalid      (ds_tvalid),
        .ds_tready      (ds_tready),
        .pix_tvalid     (pix_tvalid),
        .pix_tready     (pix_tready),
        .pipe_ap_start  (pipe_ap_start),
        .pipe_reset     (pipe_reset),
        .pipe_crop_x0   (pipe_crop_x0),
        .pipe_crop_y0   (pipe_crop_y0),
        .sts_busy       (sts_busy),
        .sts_frame_done (sts_frame_done),
        .sts_frame_cnt  (sts_frame_cnt),
        .sts_timeout    (sts_timeout),
        .sts_cfg_err    (sts_cfg_err)
    );

    int checks = 0;
    int failures = 0;

    int mon_beats = 0;
    int mon_ap = 0;
    int mon_done = 0;
    int crop_dev = 0;
    bit crop_watch = 1'b0;
    logic [5:0] exp_x = '0, exp_y = '0;

    // Event tallies are taken mid-cycle, where the combinational gating has settled.
    always @(negedge clk) begin
        if (ds_tvalid && ds_tready) mon_beats++;
        if (pipe_ap_start) mon_ap++;
        if (sts_frame_done) mon_done++;
        if (crop_watch && sts_busy && !pipe_ap_start &&
            (pipe_crop_x0 !== exp_x || pipe_crop_y0 !== exp_y)) crop_dev++;
    end

    initial begin
        #2ms;
        $display("FAIL sim_timeout: got no summary, required completion within 2ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        ctrl_enable = 1'b0; ctrl_continuous = 1'b0; ctrl_abort = 1'b0; cfg_we = 1'b0;
        cfg_crop_x0 = '0; cfg_crop_y0 = '0;
        us_tvalid = 1'b0; ds_tready = 1'b0; pix_tvalid = 1'b0; pix_tready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic set_crop(input logic [5:0] x, input logic [5:0] y);
        cfg_we = 1'b1; cfg_crop_x0 = x; cfg_crop_y0 = y;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (mon_beats < target && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic pump_pixels(input int n);
        pix_tvalid = 1'b1; pix_tready = 1'b1;
        repeat (n) tick();
        pix_tvalid = 1'b0; pix_tready = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        int n = 0;
        got = 1'b0;
        while (!got && n < 16) begin
            if (sts_frame_done === 1'b1) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl_enable = 1'b0; ctrl_continuous = 1'b0; ctrl_abort = 1'b0; cfg_we = 1'b0;
        cfg_crop_x0 = '0; cfg_crop_y0 = '0;
        us_tvalid = 1'b1; ds_tready = 1'b1; pix_tvalid = 1'b0; pix_tready = 1'b0;
        tick(); tick();
        checks++;
        if (pipe_reset !== 1'b1) begin
            failures++; $display("FAIL reset_pipe_reset: got %b required 1", pipe_reset);
        end
        checks++;
        if ({sts_busy, pipe_ap_start, sts_frame_done, sts_timeout, sts_cfg_err, us_tready, ds_tvalid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {sts_busy, pipe_ap_start, sts_frame_done, sts_timeout, sts_cfg_err, us_tready, ds_tvalid});
        end
        checks++;
        if ({sts_frame_cnt, pipe_crop_x0, pipe_crop_y0} !== 44'd0) begin
            failures++;
            $display("FAIL reset_values: got cnt=%0d x0=%0d y0=%0d required 0/0/0", sts_frame_cnt, pipe_crop_x0, pipe_crop_y0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (pipe_reset !== 1'b0) begin
            failures++; $display("FAIL reset_release: got pipe_reset=%b required 0", pipe_reset);
        end
    endtask

    task automatic test_single_shot();
        int b0, a0, d0;
        bit got;
        apply_reset();
        set_crop(6'd16, 6'd16);
        b0 = mon_beats; a0 = mon_ap; d0 = mon_done;
        ctrl_enable = 1'b1; us_tvalid = 1'b1; ds_tready = 1'b1;
        tick();
        checks++;
        if (pipe_ap_start !== 1'b1) begin
            failures++; $display("FAIL single_ap_start: got %b required 1", pipe_ap_start);
        end
        wait_beats(b0 + 128);
        repeat (3) tick();
        checks++;
        if (mon_beats - b0 !== 128) begin
            failures++; $display("FAIL single_beats: got %0d required 128", mon_beats - b0);
        end
        checks++;
        if (us_tready !== 1'b0) begin
            failures++; $display("FAIL single_us_tready_closed: got %b required 0", us_tready);
        end
        pump_pixels(1024);
        wait_done(got);
        checks++;
        if (got !== 1'b1 || sts_frame_cnt !== 32'd1) begin
            failures++; $display("FAIL single_done: got done=%b cnt=%0d required 1/1", got, sts_frame_cnt);
        end
        repeat (4) tick();
        checks++;
        if (mon_ap - a0 !== 1 || mon_done - d0 !== 1) begin
            failures++; $display("FAIL single_pulses: got ap=%0d done=%0d required 1/1", mon_ap - a0, mon_done - d0);
        end
        checks++;
        if (sts_busy !== 1'b0 || pipe_crop_x0 !== 6'd16 || pipe_crop_y0 !== 6'd16) begin
            failures++;
            $display("FAIL single_idle: got busy=%b x0=%0d y0=%0d required 0/16/16", sts_busy, pipe_crop_x0, pipe_crop_y0);
        end
    endtask

    task automatic test_continuous();
        int b0, a0;
        bit g1, g2, g3;
        apply_reset();
        set_crop(6'd16, 6'd16);
        exp_x = 6'd16; exp_y = 6'd16;
        b0 = mon_beats; a0 = mon_ap; crop_dev = 0; crop_watch = 1'b1;
        ctrl_continuous = 1'b1; ctrl_enable = 1'b1; us_tvalid = 1'b1; ds_tready = 1'b1;
        wait_beats(b0 + 128);
        pump_pixels(1024);
        wait_done(g1);
        wait_beats(b0 + 148);
        set_crop(6'd8, 6'd4);
        checks++;
        if (sts_cfg_err !== 1'b0) begin
            failures++; $display("FAIL cont_cfg_accept: got cfg_err=%b required 0", sts_cfg_err);
        end
        wait_beats(b0 + 256);
        pump_pixels(1024);
        wait_done(g2);
        exp_x = 6'd8; exp_y = 6'd4;
        wait_beats(b0 + 266);
        checks++;
        if (pipe_crop_x0 !== 6'd8 || pipe_crop_y0 !== 6'd4) begin
            failures++; $display("FAIL cont_frame3_crop: got %0d,%0d required 8,4", pipe_crop_x0, pipe_crop_y0);
        end
        ctrl_continuous = 1'b0;
        wait_beats(b0 + 384);
        pump_pixels(1024);
        wait_done(g3);
        repeat (4) tick();
        crop_watch = 1'b0;
        checks++;
        if ({g1, g2, g3} !== 3'b111 || sts_frame_cnt !== 32'd3) begin
            failures++; $display("FAIL cont_frames: got done=%b cnt=%0d required 111/3", {g1, g2, g3}, sts_frame_cnt);
        end
        checks++;
        if (mon_ap - a0 !== 3 || sts_busy !== 1'b0) begin
            failures++; $display("FAIL cont_arms: got ap=%0d busy=%b required 3/0", mon_ap - a0, sts_busy);
        end
        checks++;
        if (crop_dev !== 0) begin
            failures++; $display("FAIL cont_crop_stable: got %0d deviating cycles required 0", crop_dev);
        end
    endtask

    task automatic test_cfg_err();
        int b0;
        apply_reset();
        set_crop(6'd32, 6'd32);
        checks++;
        if (sts_cfg_err !== 1'b0) begin
            failures++; $display("FAIL cfg_edge_accept: got cfg_err=%b required 0", sts_cfg_err);
        end
        set_crop(6'd16, 6'd16);
        set_crop(6'd40, 6'd0);
        checks++;
        if (sts_cfg_err !== 1'b1) begin
            failures++; $display("FAIL cfg_err_set: got %b required 1", sts_cfg_err);
        end
        b0 = mon_beats;
        ctrl_enable = 1'b1; us_tvalid = 1'b1; ds_tready = 1'b1;
        tick();
        checks++;
        if (sts_cfg_err !== 1'b0) begin
            failures++; $display("FAIL cfg_err_clear_on_enable: got %b required 0", sts_cfg_err);
        end
        wait_beats(b0 + 5);
        checks++;
        if (pipe_crop_x0 !== 6'd16 || pipe_crop_y0 !== 6'd16) begin
            failures++; $display("FAIL cfg_err_crop_kept: got %0d,%0d required 16,16", pipe_crop_x0, pipe_crop_y0);
        end
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        checks++;
        if (pipe_reset !== 1'b1 || sts_timeout !== 1'b0) begin
            failures++; $display("FAIL cfg_abort_flush: got pipe_reset=%b timeout=%b required 1/0", pipe_reset, sts_timeout);
        end
        repeat (6) tick();
    endtask

    task automatic test_timeout();
        int b0, n;
        apply_reset();
        set_crop(6'd16, 6'd16);
        b0 = mon_beats;
        ctrl_enable = 1'b1; us_tvalid = 1'b1; ds_tready = 1'b1;
        wait_beats(b0 + 10);
        ds_tready = 1'b0;
        repeat (63) tick();
        checks++;
        if (sts_timeout !== 1'b0 || pipe_reset !== 1'b0 || sts_busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got timeout=%b pipe_reset=%b busy=%b required 0/0/1", sts_timeout, pipe_reset, sts_busy);
        end
        tick();
        checks++;
        if (sts_timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_set: got %b required 1", sts_timeout);
        end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (pipe_reset === 1'b1) n++;
            tick();
        end
        checks++;
        if (n !== 4 || pipe_reset !== 1'b0 || sts_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_flush: got %0d reset cycles, then pipe_reset=%b busy=%b required 4/0/0", n, pipe_reset, sts_busy);
        end
        checks++;
        if (sts_frame_cnt !== 32'd0 || mon_beats - b0 !== 10) begin
            failures++; $display("FAIL timeout_counts: got cnt=%0d beats=%0d required 0/10", sts_frame_cnt, mon_beats - b0);
        end
        ctrl_enable = 1'b0;
        tick();
        ctrl_enable = 1'b1;
        tick();
        checks++;
        if (sts_timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_clear_on_enable: got %b required 0", sts_timeout);
        end
    endtask

    task automatic test_abort_last_pixel();
        int b0, d0;
        apply_reset();
        set_crop(6'd16, 6'd16);
        b0 = mon_beats; d0 = mon_done;
        ctrl_enable = 1'b1; us_tvalid = 1'b1; ds_tready = 1'b1;
        wait_beats(b0 + 128);
        pump_pixels(1023);
        pix_tvalid = 1'b1; pix_tready = 1'b1; ctrl_abort = 1'b1;
        tick();
        pix_tvalid = 1'b0; pix_tready = 1'b0; ctrl_abort = 1'b0;
        checks++;
        if (pipe_reset !== 1'b1 || sts_frame_done !== 1'b0) begin
            failures++; $display("FAIL abort_flush: got pipe_reset=%b done=%b required 1/0", pipe_reset, sts_frame_done);
        end
        repeat (8) tick();
        checks++;
        if (mon_done - d0 !== 0 || sts_frame_cnt !== 32'd0) begin
            failures++; $display("FAIL abort_no_done: got done=%0d cnt=%0d required 0/0", mon_done - d0, sts_frame_cnt);
        end
        checks++;
        if (sts_busy !== 1'b0 || pipe_reset !== 1'b0 || sts_timeout !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b pipe_reset=%b timeout=%b required 0/0/0", sts_busy, pipe_reset, sts_timeout);
        end
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        tick();
        checks++;
        if (pipe_reset !== 1'b0 || sts_busy !== 1'b0) begin
            failures++; $display("FAIL abort_in_idle: got pipe_reset=%b busy=%b required 0/0", pipe_reset, sts_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int b0;
        apply_reset();
        set_crop(6'd16, 6'd16);
        b0 = mon_beats;
        ctrl_enable = 1'b1; us_tvalid = 1'b1; ds_tready = 1'b1;
        wait_beats(b0 + 50);
        reset = 1'b1; ctrl_enable = 1'b0;
        tick();
        checks++;
        if (pipe_reset !== 1'b1 ||
            {sts_busy, pipe_ap_start, sts_frame_done, us_tready, ds_tvalid} !== 5'b0 ||
            {sts_frame_cnt, pipe_crop_x0, pipe_crop_y0} !== 44'd0) begin
            failures++;
            $display("FAIL midrun_reset_values: got pipe_reset=%b flags=%b x0=%0d required 1/00000/0",
                     pipe_reset, {sts_busy, pipe_ap_start, sts_frame_done, us_tready, ds_tvalid}, pipe_crop_x0);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (pipe_reset !== 1'b0 || sts_busy !== 1'b0) begin
            failures++; $display("FAIL midrun_after_reset: got pipe_reset=%b busy=%b required 0/0", pipe_reset, sts_busy);
        end
        b0 = mon_beats;
        ctrl_enable = 1'b1;
        wait_beats(b0 + 128);
        repeat (4) tick();
        checks++;
        if (mon_beats - b0 !== 128 || us_tready !== 1'b0) begin
            failures++; $display("FAIL midrun_next_frame: got beats=%0d us_tready=%b required 128/0", mon_beats - b0, us_tready);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_cfg_err();
        test_timeout();
        test_abort_last_pixel();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
